// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder pins in, position-counter controls out
// Ports:
//   a_in, b_in, idx_in  raw asynchronous encoder channels
//   step, dir, load     counter ce / up_down / load controls
//   err, err_cnt        illegal-transition pulse and saturating count
//   ab_state            current filtered {A,B}
// slave is the decoder side, master is the board/counter side.
interface quad_decoder_if #(
    parameter int ERR_W = 8
);
    logic             a_in;
    logic             b_in;
    logic             idx_in;
    logic             step;
    logic             dir;
    logic             load;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       ab_state;
    modport master (
        output a_in, b_in, idx_in,
        input  step, dir, load, err, err_cnt, ab_state
    );
    modport slave (
        input  a_in, b_in, idx_in,
        output step, dir, load, err, err_cnt, ab_state
    );
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder: synchronise, glitch-filter and decode A/B/index into counter controls
// Ports:
//   clk  system clock, rst synchronous active-high reset
//   bus  quad_decoder_if.slave: raw pins in, step/dir/load/err/err_cnt/ab_state out
// Parameters:
//   FILT_LEN  consecutive differing samples needed to move a filtered level (>=1)
//   ERR_W     width of the saturating illegal-transition counter (must match bus)
module quad_decoder #(
    parameter int FILT_LEN = 3,
    parameter int ERR_W    = 8
) (
    input logic          clk,
    input logic          rst,
    quad_decoder_if.slave bus
);
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam int IW = $clog2(FILT_LEN + 3);
    typedef enum logic {INIT, RUN} state_t;
    state_t           state;
    // channel vectors are packed {a, b, idx}
    logic [2:0]       s1, s2, filt;
    logic [CW-1:0]    fcnt [3];
    logic [IW-1:0]    icnt;
    logic [1:0]       prev_ab;
    logic             prev_idx;
    logic             step_q, dir_q, load_q, err_q;
    logic [ERR_W-1:0] cnt_q;
    logic [1:0]       pos_new, pos_old, delta;
    logic             rise;
    // Gray {A,B} mapped to a position 0..3; the position delta mod 4 classifies
    // the move: 1 forward, 3 reverse, 2 both bits flipped (illegal), 0 idle.
    assign pos_new = {filt[2], filt[2] ^ filt[1]};
    assign pos_old = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
    assign delta   = pos_new - pos_old;
    assign rise    = filt[0] & ~prev_idx;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            filt <= '0;
            for (int i = 0; i < 3; i++) fcnt[i] <= '0;
        end else begin
            s1 <= {bus.a_in, bus.b_in, bus.idx_in};
            s2 <= s1;
            if (state == INIT) begin
                for (int i = 0; i < 3; i++) fcnt[i] <= '0;
                // pin levels present at startup are adopted silently
                if (icnt == IW'(FILT_LEN + 1)) filt <= s2;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (s2[i] == filt[i]) begin
                        fcnt[i] <= '0;
                    end else if (fcnt[i] == CW'(FILT_LEN - 1)) begin
                        filt[i] <= s2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 1'b1;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            icnt     <= '0;
            prev_ab  <= '0;
            prev_idx <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b1;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (state == INIT) begin
            step_q <= 1'b0;
            load_q <= 1'b0;
            err_q  <= 1'b0;
            if (icnt == IW'(FILT_LEN + 1)) begin
                prev_ab  <= s2[2:1];
                prev_idx <= s2[0];
                state    <= RUN;
            end else begin
                icnt <= icnt + 1'b1;
            end
        end else begin
            prev_ab  <= filt[2:1];
            prev_idx <= filt[0];
            // index forces ce so the counter load takes effect; it also freezes dir
            step_q   <= rise | delta[0];
            dir_q    <= (!rise && delta[0]) ? ~delta[1] : dir_q;
            load_q   <= rise;
            err_q    <= delta == 2'd2;
            cnt_q    <= (delta == 2'd2 && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        end
    end
    assign bus.step     = step_q;
    assign bus.dir      = dir_q;
    assign bus.load     = load_q;
    assign bus.err      = err_q;
    assign bus.err_cnt  = cnt_q;
    assign bus.ab_state = filt[2:1];
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: randomized scoreboard bench for quad_decoder
module tb_quad_decoder;
    localparam int FL = 3;
    localparam int EW = 2;
    typedef struct {
        int          cyc;
        logic        step;
        logic        dir;
        logic        load;
        logic        err;
        logic [EW-1:0] cnt;
        logic [1:0]  ab;
    } ev_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    ev_t  q[$];
    ev_t  mon_e;
    logic exp_dir = 1'b1;
    logic [1:0] gseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] m_ab;
    logic       m_idx;
    logic       m_dir;
    int         m_cnt;
    quad_decoder_if #(.ERR_W(EW)) bus ();
    quad_decoder #(.FILT_LEN(FL), .ERR_W(EW)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic int pos(logic [1:0] g);
        for (int i = 0; i < 4; i++) if (gseq[i] == g) return i;
        return 0;
    endfunction
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // Expected response of the encoder rules to new pin levels, pushed to the scoreboard.
    task automatic drive(logic [1:0] ab, logic idx);
        ev_t e;
        int  d;
        logic r;
        r = idx & ~m_idx;
        d = (pos(ab) - pos(m_ab) + 4) % 4;
        if (r || d != 0) begin
            if (!r && d == 1) m_dir = 1'b1;
            if (!r && d == 3) m_dir = 1'b0;
            if (d == 2 && m_cnt < (1 << EW) - 1) m_cnt++;
            e.cyc  = cyc + 3 + FL;
            e.step = r || d == 1 || d == 3;
            e.dir  = m_dir;
            e.load = r;
            e.err  = d == 2;
            e.cnt  = EW'(m_cnt);
            e.ab   = ab;
            q.push_back(e);
        end
        m_ab = ab;
        m_idx = idx;
        {bus.a_in, bus.b_in} = ab;
        bus.idx_in = idx;
    endtask
    task automatic glitch(int pin, int w);
        if (pin == 0) bus.a_in = ~bus.a_in;
        else if (pin == 1) bus.b_in = ~bus.b_in;
        else bus.idx_in = ~bus.idx_in;
        tick(w);
        {bus.a_in, bus.b_in} = m_ab;
        bus.idx_in = m_idx;
    endtask
    function automatic logic [1:0] nxt(int k);
        return gseq[(pos(m_ab) + k) % 4];
    endfunction
    always @(negedge clk) begin
        if (rst) begin
            exp_dir = 1'b1;
        end else begin
            if (q.size() > 0 && cyc > q[0].cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_event: no output, event required at cycle %0d (now %0d)", q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (bus.step || bus.err || bus.load) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: step=%b load=%b err=%b at cycle %0d, none required", bus.step, bus.load, bus.err, cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("ev_cycle", cyc, mon_e.cyc);
                    check("ev_step", bus.step, mon_e.step);
                    check("ev_dir", bus.dir, mon_e.dir);
                    check("ev_load", bus.load, mon_e.load);
                    check("ev_err", bus.err, mon_e.err);
                    check("ev_err_cnt", bus.err_cnt, mon_e.cnt);
                    check("ev_ab_state", bus.ab_state, mon_e.ab);
                    exp_dir = mon_e.dir;
                end
            end else begin
                check("dir_hold", bus.dir, exp_dir);
            end
        end
    end
    initial begin
        bus.a_in = 1'b1;
        bus.b_in = 1'b1;
        bus.idx_in = 1'b1;
        m_ab = 2'b11;
        m_idx = 1'b1;
        m_dir = 1'b1;
        m_cnt = 0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_step", bus.step, 0);
        check("rst_load", bus.load, 0);
        check("rst_err", bus.err, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        check("rst_dir", bus.dir, 1);
        check("rst_ab_state", bus.ab_state, 0);
        tick(12);
        check("init_ab_state", bus.ab_state, 2'b11);
        check("init_dir", bus.dir, 1);
        for (int i = 0; i < 8; i++) begin
            drive(nxt(1), m_idx);
            tick(4);
        end
        for (int i = 0; i < 4; i++) begin
            drive(nxt(3), m_idx);
            tick(4);
        end
        drive(nxt(1), m_idx);
        tick(8);
        glitch(0, 2);
        tick(8);
        for (int i = 0; i < 5; i++) begin
            drive(nxt(2), m_idx);
            tick(5);
        end
        drive(m_ab, 1'b0);
        tick(5);
        drive(m_ab, 1'b1);
        tick(5);
        drive(m_ab, 1'b0);
        tick(5);
        drive(nxt(1), 1'b1);
        tick(5);
        drive(m_ab, 1'b0);
        tick(5);
        drive(nxt(2), 1'b1);
        tick(12);
        bus.a_in = ~bus.a_in;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_step", bus.step, 0);
        check("mid_rst_err_cnt", bus.err_cnt, 0);
        check("mid_rst_dir", bus.dir, 1);
        check("mid_rst_ab_state", bus.ab_state, 0);
        m_ab = {bus.a_in, bus.b_in};
        m_idx = bus.idx_in;
        m_dir = 1'b1;
        m_cnt = 0;
        tick(12);
        check("mid_rst_init_ab", bus.ab_state, m_ab);
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 6))
                0: drive(nxt(1), m_idx);
                1: drive(nxt(3), m_idx);
                2: drive(nxt(2), m_idx);
                3: drive(m_ab, ~m_idx);
                4: glitch($urandom_range(0, 2), $urandom_range(1, FL - 1));
                5: drive(nxt($urandom_range(0, 1) ? 1 : 3), ~m_idx);
                default: drive(nxt(2), ~m_idx);
            endcase
            tick($urandom_range(4, 8));
        end
        tick(20);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
